// File: rtl/rambus_pkg.sv
// Shared types and helpers for the banked Wishbone RAM slave and its bank model.
package rambus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int WAIT_CNT_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int sel_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rambus_bank.sv
// Single-port RAM bank: registered read, per-byte write enables.
// Behavioural stand-in for the gf180 SRAM macro; keep the port list stable.
module rambus_bank
    import rambus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [sel_w(DATA_W)-1:0]   sel,
    input  logic [AW-1:0]              addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int SEL_W = sel_w(DATA_W);

    logic [DATA_W-1:0] mem [2**AW];

    // Byte-lane write or registered read; rdata holds its value across writes
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (sel[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/rambus_banked.sv
// Wishbone classic slave in front of N_BANKS single-port SRAM banks.
// Optional feature macro: RAMBUS_BANKED_ERR_EN (out-of-range accesses end
// with rambus_wb_err_o instead of rambus_wb_ack_o).
//
// state  | meaning
// IDLE   | waiting for cyc&stb; request fields latched on accept
// ACCESS | bank op issued if cyc&stb still high, else abort
// WAIT   | counting down WAIT_STATES cycles, abort on dropped cyc/stb
// ACK    | one-cycle ack (or err) pulse, then back to IDLE
module rambus_banked
    import rambus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BANK_AW     = 9,
    parameter int N_BANKS     = 2,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                      rambus_wb_clk_i,
    input  logic                      rambus_wb_rst_i,
    input  logic                      rambus_wb_cyc_i,
    input  logic                      rambus_wb_stb_i,
    input  logic                      rambus_wb_we_i,
    input  logic [ADDR_W-1:0]         rambus_wb_addr_i,
    input  logic [sel_w(DATA_W)-1:0]  rambus_wb_sel_i,
    input  logic [DATA_W-1:0]         rambus_wb_dat_i,
    output logic [DATA_W-1:0]         rambus_wb_dat_o,
    output logic                      rambus_wb_ack_o
`ifdef RAMBUS_BANKED_ERR_EN
    ,
    output logic                      rambus_wb_err_o
`endif
);

    localparam int SEL_W = sel_w(DATA_W);

    state_t                  state;
    logic [ADDR_W-1:0]       addr_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_W-1:0]       dat_q;
    logic                    we_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    ack_q;
    logic                    ack_rd_q;
    logic                    req;
    logic                    access_go;
    logic                    enter_ack;
    logic                    in_range;
    logic [31:0]             bank_idx;
    logic [N_BANKS-1:0]      bank_en;
    logic [DATA_W-1:0]       bank_rdata [N_BANKS];
    logic [DATA_W-1:0]       rd_mux;

    assign req      = rambus_wb_cyc_i && rambus_wb_stb_i;
    assign bank_idx = 32'(addr_q >> BANK_AW);
    assign in_range = bank_idx < 32'(N_BANKS);

    // Bank strobe only in ACCESS with the request still present; reset blocks commits
    assign access_go = (state == ACCESS) && req && !rambus_wb_rst_i;

    // Last cycle before ACK: end of ACCESS (no wait states) or the final wait cycle
    assign enter_ack = req && (((state == ACCESS) && (WAIT_STATES == 0)) ||
                               ((state == WAIT) && (wait_cnt == '0)));

    // One-hot bank enable; an out-of-range index enables nothing
    always_comb begin
        bank_en = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_en[b] = access_go && (bank_idx == 32'(b));
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < N_BANKS; gb++) begin : g_bank
            rambus_bank #(
                .DATA_W (DATA_W),
                .AW     (BANK_AW)
            ) u_bank (
                .clk   (rambus_wb_clk_i),
                .en    (bank_en[gb]),
                .we    (we_q),
                .sel   (sel_q),
                .addr  (addr_q[BANK_AW-1:0]),
                .wdata (dat_q),
                .rdata (bank_rdata[gb])
            );
        end
    endgenerate

    // Read data from the addressed bank; zero when no bank matches
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (bank_idx == 32'(b)) rd_mux = bank_rdata[b];
        end
    end

    // The bank output register is the data register; it is only exposed during a read ack
    assign rambus_wb_dat_o = ack_rd_q ? rd_mux : '0;
    assign rambus_wb_ack_o = ack_q;

`ifdef RAMBUS_BANKED_ERR_EN
    logic err_q;
    assign rambus_wb_err_o = err_q;
`endif

    // Transaction FSM with registered ack/err
    always_ff @(posedge rambus_wb_clk_i) begin
        if (rambus_wb_rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            ack_rd_q <= 1'b0;
`ifdef RAMBUS_BANKED_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            ack_q    <= 1'b0;
            ack_rd_q <= 1'b0;
`ifdef RAMBUS_BANKED_ERR_EN
            err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= rambus_wb_addr_i;
                        sel_q  <= rambus_wb_sel_i;
                        dat_q  <= rambus_wb_dat_i;
                        we_q   <= rambus_wb_we_i;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (WAIT_STATES > 0) begin
                        wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                        state    <= WAIT;
                    end else begin
                        state <= ACK;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_ack) begin
`ifdef RAMBUS_BANKED_ERR_EN
                if (!in_range) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q    <= 1'b1;
                    ack_rd_q <= !we_q;
                end
`else
                ack_q    <= 1'b1;
                ack_rd_q <= !we_q && in_range;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rambus_banked.sv
// Directed bench for rambus_banked: four instances cover the default build,
// WAIT_STATES=3, WAIT_STATES=2 and a three-bank out-of-range configuration.
module tb_rambus_banked;

    logic        clk;
    logic        rst;
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic [3:0]  we;
    logic [10:0] addr [4];
    logic [3:0]  sel  [4];
    logic [31:0] wdat [4];
    wire  [31:0] rdat [4];
    wire  [3:0]  ack;
    wire  [3:0]  err;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rambus_banked u_d0 (
        .rambus_wb_clk_i (clk), .rambus_wb_rst_i (rst),
        .rambus_wb_cyc_i (cyc[0]), .rambus_wb_stb_i (stb[0]), .rambus_wb_we_i (we[0]),
        .rambus_wb_addr_i (addr[0][9:0]), .rambus_wb_sel_i (sel[0]), .rambus_wb_dat_i (wdat[0]),
        .rambus_wb_dat_o (rdat[0]), .rambus_wb_ack_o (ack[0])
`ifdef RAMBUS_BANKED_ERR_EN
        , .rambus_wb_err_o (err[0])
`endif
    );

    rambus_banked #(.WAIT_STATES(3)) u_d1 (
        .rambus_wb_clk_i (clk), .rambus_wb_rst_i (rst),
        .rambus_wb_cyc_i (cyc[1]), .rambus_wb_stb_i (stb[1]), .rambus_wb_we_i (we[1]),
        .rambus_wb_addr_i (addr[1][9:0]), .rambus_wb_sel_i (sel[1]), .rambus_wb_dat_i (wdat[1]),
        .rambus_wb_dat_o (rdat[1]), .rambus_wb_ack_o (ack[1])
`ifdef RAMBUS_BANKED_ERR_EN
        , .rambus_wb_err_o (err[1])
`endif
    );

    rambus_banked #(.WAIT_STATES(2)) u_d2 (
        .rambus_wb_clk_i (clk), .rambus_wb_rst_i (rst),
        .rambus_wb_cyc_i (cyc[2]), .rambus_wb_stb_i (stb[2]), .rambus_wb_we_i (we[2]),
        .rambus_wb_addr_i (addr[2][9:0]), .rambus_wb_sel_i (sel[2]), .rambus_wb_dat_i (wdat[2]),
        .rambus_wb_dat_o (rdat[2]), .rambus_wb_ack_o (ack[2])
`ifdef RAMBUS_BANKED_ERR_EN
        , .rambus_wb_err_o (err[2])
`endif
    );

    rambus_banked #(.N_BANKS(3), .ADDR_W(11)) u_d3 (
        .rambus_wb_clk_i (clk), .rambus_wb_rst_i (rst),
        .rambus_wb_cyc_i (cyc[3]), .rambus_wb_stb_i (stb[3]), .rambus_wb_we_i (we[3]),
        .rambus_wb_addr_i (addr[3]), .rambus_wb_sel_i (sel[3]), .rambus_wb_dat_i (wdat[3]),
        .rambus_wb_dat_o (rdat[3]), .rambus_wb_ack_o (ack[3])
`ifdef RAMBUS_BANKED_ERR_EN
        , .rambus_wb_err_o (err[3])
`endif
    );

`ifndef RAMBUS_BANKED_ERR_EN
    assign err = 4'b0000;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transaction; lat counts rising edges from request to ack/err (-1 on timeout)
    task automatic xact(input int k, input logic w, input logic [10:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdat[k] = d;
        lat = -1; rd = '0; got_ack = 1'b0; got_err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) begin
                lat = n; rd = rdat[k]; got_ack = ack[k]; got_err = err[k];
                break;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input int k, input logic [10:0] a, input logic [3:0] s,
                            input logic [31:0] d, input int exp_lat, input string tag);
        logic [31:0] rd; int lat; logic ga, ge;
        xact(k, 1'b1, a, s, d, rd, lat, ga, ge);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ack"}, {31'b0, ga}, 32'd1);
        check({tag, "_dat0"}, rd, 32'h0);
    endtask

    task automatic do_read(input int k, input logic [10:0] a, input logic [31:0] exp,
                           input int exp_lat, input string tag);
        logic [31:0] rd; int lat; logic ga, ge;
        xact(k, 1'b0, a, 4'hF, 32'h0, rd, lat, ga, ge);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dat"}, rd, exp);
    endtask

    // Start a write, drop cyc/stb after n_edges rising edges, then require silence
    task automatic abort_wr(input int k, input logic [10:0] a, input logic [31:0] d,
                            input int n_edges, input string tag);
        int acks;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; addr[k] = a; sel[k] = 4'hF; wdat[k] = d;
        repeat (n_edges) @(posedge clk);
        #1;
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) acks++;
        end
        check({tag, "_noack"}, 32'(acks), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        int          acks, first_at, second_at;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0;
        for (int k = 0; k < 4; k++) begin
            addr[k] = '0; sel[k] = '0; wdat[k] = '0;
        end

        repeat (3) begin
            @(negedge clk);
            check("rst_ack", {31'b0, ack[0]}, 32'd0);
        end
        rst = 1'b0;

        // Preload word 0, reset again, then read it back: reset leaves memory intact
        do_write(0, 11'h000, 4'hF, 32'h5A5A1234, 2, "pre0");
        @(negedge clk); rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst2_ack", {31'b0, ack[0]}, 32'd0);
            check("rst2_dat", rdat[0], 32'h0);
        end
        rst = 1'b0;
        do_read(0, 11'h000, 32'h5A5A1234, 2, "rd0");

        // Independent banks
        do_write(0, 11'h005, 4'hF, 32'hDEADBEEF, 2, "wr_b0");
        do_write(0, 11'h205, 4'hF, 32'h12345678, 2, "wr_b1");
        do_read(0, 11'h005, 32'hDEADBEEF, 2, "rd_b0");
        do_read(0, 11'h205, 32'h12345678, 2, "rd_b1");

        // Byte lanes and empty sel
        do_write(0, 11'h010, 4'hF, 32'hAABBCCDD, 2, "wr_full");
        do_write(0, 11'h010, 4'b0101, 32'h11223344, 2, "wr_part");
        do_read(0, 11'h010, 32'hAA22CC44, 2, "rd_part");
        do_write(0, 11'h010, 4'b0000, 32'hFFFFFFFF, 2, "wr_sel0");
        do_read(0, 11'h010, 32'hAA22CC44, 2, "rd_sel0");

        // Wait states
        do_write(1, 11'h003, 4'hF, 32'h0F0F0F0F, 5, "ws3_wr");
        do_read(1, 11'h003, 32'h0F0F0F0F, 5, "ws3_rd");

        // Held strobe: acks at edges 5 and 11 only
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 11'h003; sel[1] = 4'hF;
        acks = 0; first_at = -1; second_at = -1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (ack[1]) begin
                acks++;
                if (first_at < 0) first_at = n;
                else if (second_at < 0) second_at = n;
            end
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (4) @(posedge clk);
        check("hold_count", 32'(acks), 32'd2);
        check("hold_first", 32'(first_at), 32'd5);
        check("hold_second", 32'(second_at), 32'd11);

        // Abort in ACCESS suppresses the write
        do_write(0, 11'h020, 4'hF, 32'h11111111, 2, "ab_pre0");
        abort_wr(0, 11'h020, 32'hCAFEF00D, 1, "ab_access");
        do_read(0, 11'h020, 32'h11111111, 2, "ab_access_rd");

        // Abort in WAIT keeps the committed write
        do_write(2, 11'h020, 4'hF, 32'h11111111, 4, "ab_pre2");
        abort_wr(2, 11'h020, 32'hCAFEF00D, 2, "ab_wait");
        do_read(2, 11'h020, 32'hCAFEF00D, 4, "ab_wait_rd");

        // Reset during ACCESS: no ack and no commit
        do_write(0, 11'h030, 4'hF, 32'h22222222, 2, "rm_pre");
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 11'h030; sel[0] = 4'hF;
        wdat[0] = 32'h99999999;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        acks = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
        end
        check("rm_noack", 32'(acks), 32'd0);
        do_read(0, 11'h030, 32'h22222222, 2, "rm_rd");

        // Out-of-range bank on the three-bank instance
        do_write(3, 11'h000, 4'hF, 32'hA0A0A0A0, 2, "oor_pre0");
        do_write(3, 11'h200, 4'hF, 32'hB1B1B1B1, 2, "oor_pre1");
        do_write(3, 11'h400, 4'hF, 32'hC2C2C2C2, 2, "oor_pre2");
        xact(3, 1'b1, 11'h600, 4'hF, 32'h77777777, rd, lat, ga, ge);
        check("oor_wr_lat", 32'(lat), 32'd2);
        xact(3, 1'b0, 11'h600, 4'hF, 32'h0, rd, lat, ga, ge);
        check("oor_rd_lat", 32'(lat), 32'd2);
        check("oor_rd_dat", rd, 32'h0);
`ifdef RAMBUS_BANKED_ERR_EN
        check("oor_rd_err", {31'b0, ge}, 32'd1);
        check("oor_rd_ack", {31'b0, ga}, 32'd0);
`else
        check("oor_rd_ack", {31'b0, ga}, 32'd1);
        check("oor_rd_err", {31'b0, ge}, 32'd0);
`endif
        do_read(3, 11'h000, 32'hA0A0A0A0, 2, "oor_b0");
        do_read(3, 11'h200, 32'hB1B1B1B1, 2, "oor_b1");
        do_read(3, 11'h400, 32'hC2C2C2C2, 2, "oor_b2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
